// File: rtl/req_ack_if.sv
// req_ack_if: single-cycle request/acknowledge link between a requester and a responder.
//   req : request pulse, driven by the requester (master)
//   ack : acknowledge pulse, driven by the responder (slave)
interface req_ack_if;
    logic req;
    logic ack;

    modport master (output req, input ack);
    modport slave  (input req, output ack);
endinterface

// File: rtl/req_ack_responder.sv
// req_ack_responder: returns a single-cycle ack exactly LATENCY edges after each
// accepted req pulse, and keeps request/ack tallies and a busy indication.
// Optional minimum request spacing check, enabled by the macro REQ_ACK_GAP_CHECK_EN:
// requests closer than MIN_GAP edges to the previous accepted one are dropped
// and a sticky err flag is raised.
// Ports:
//   clk        : sole clock, rising edge
//   rst_n      : synchronous active-low reset
//   link       : req_ack_if.slave (req in, ack out; ack is registered)
//   busy       : high while any accepted request awaits its ack
//   reqs_seen  : count of edges with req=1 (accepted or dropped), wraps
//   acks_seen  : count of edges with ack=1, wraps
//   err        : sticky spacing-violation flag (0 when the check is compiled out)
module req_ack_responder #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned MIN_GAP = 8,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    req_ack_if.slave         link,
    output logic             busy,
    output logic [CNT_W-1:0] reqs_seen,
    output logic [CNT_W-1:0] acks_seen,
    output logic             err
);

    logic [LATENCY-1:0] pend_q, pend_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   reqs_q, reqs_d;
    logic [CNT_W-1:0]   acks_q, acks_d;
    logic               req_acc;

`ifdef REQ_ACK_GAP_CHECK_EN
    localparam int unsigned GAP_W = $clog2(MIN_GAP + 1);

    logic [GAP_W-1:0] gap_q, gap_d;
    logic             err_q, err_d;

    // Spacing check: gap counts edges since the last accepted request, saturating at MIN_GAP.
    always_comb begin
        req_acc = 1'b0;
        gap_d   = gap_q;
        err_d   = err_q;
        if (link.req && (gap_q >= GAP_W'(MIN_GAP))) begin
            req_acc = 1'b1;
            gap_d   = GAP_W'(1);
        end else begin
            if (gap_q < GAP_W'(MIN_GAP)) begin
                gap_d = gap_q + GAP_W'(1);
            end
            // Dropped request does not reload gap.
            if (link.req) begin
                err_d = 1'b1;
            end
        end
    end

    // Reset to MIN_GAP so the first request is accepted immediately.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gap_q <= GAP_W'(MIN_GAP);
            err_q <= 1'b0;
        end else begin
            gap_q <= gap_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign req_acc = link.req;
    assign err     = 1'b0;
`endif

    // Delay line, busy and tally next-state.
    always_comb begin
        pend_d    = '0;
        pend_d[0] = req_acc;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            pend_d[i] = pend_q[i-1];
        end
        // Registered copy of the OR of the delay line as it will be after this edge.
        busy_d = |pend_d;
        reqs_d = reqs_q;
        acks_d = acks_q;
        if (link.req) begin
            reqs_d = reqs_q + CNT_W'(1);
        end
        if (pend_q[LATENCY-1]) begin
            acks_d = acks_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '0;
            busy_q <= 1'b0;
            reqs_q <= '0;
            acks_q <= '0;
        end else begin
            pend_q <= pend_d;
            busy_q <= busy_d;
            reqs_q <= reqs_d;
            acks_q <= acks_d;
        end
    end

    assign link.ack  = pend_q[LATENCY-1];
    assign busy      = busy_q;
    assign reqs_seen = reqs_q;
    assign acks_seen = acks_q;

endmodule
